// File: rtl/hazard_pipe_chain_if.sv
// ----------------------------------------------------------------------------
// hazard_pipe_chain_if
// Bundle of the control and status signals of hazard_pipe_chain.
//   master : the pipeline control side. It drives stall, flush, in_valid and
//            in_flags, and reads the status signals.
//   slave  : the flag chain itself. It reads the controls and drives
//            stage_valid, stage_flags, out_valid, out_flags, pending and
//            occupancy.
// Handshake: in_valid qualifies in_flags, and the entry is taken on any
// rising edge with stall=0. out_valid qualifies out_flags. The oldest entry
// leaves on the next unstalled edge whether or not anyone reads it. There is
// no ready signal, so neither side can push back on the other.
// ----------------------------------------------------------------------------
interface hazard_pipe_chain_if #(
   parameter int WIDTH = 1,
   parameter int DEPTH = 2
);
   localparam int OCC_W = $clog2(DEPTH + 1);

   logic                         stall;
   logic [DEPTH-1:0]             flush;
   logic                         in_valid;
   logic [WIDTH-1:0]             in_flags;
   logic [DEPTH-1:0]             stage_valid;
   logic [DEPTH-1:0][WIDTH-1:0]  stage_flags;
   logic                         out_valid;
   logic [WIDTH-1:0]             out_flags;
   logic [WIDTH-1:0]             pending;
   logic [OCC_W-1:0]             occupancy;

   modport master (
      output stall, flush, in_valid, in_flags,
      input  stage_valid, stage_flags, out_valid, out_flags, pending, occupancy
   );

   modport slave (
      input  stall, flush, in_valid, in_flags,
      output stage_valid, stage_flags, out_valid, out_flags, pending, occupancy
   );
endinterface

// File: rtl/hazard_pipe_chain.sv
// ----------------------------------------------------------------------------
// hazard_pipe_chain
// Carries WIDTH hazard/control flags through DEPTH pipeline stages. Stage 0
// is the youngest stage and stage DEPTH-1 is the oldest. The chain has a
// global stall and a flush for each stage. It also gives combinational
// status for all in-flight stages together: pending is the OR of the flags
// of every valid stage, and occupancy is the number of valid stages.
// Ports:
//   clk    : pipeline clock, rising edge
//   rst_n  : asynchronous, active-low reset (clears every stage to a bubble)
//   bus    : hazard_pipe_chain_if.slave
//            inputs  : stall, flush[DEPTH], in_valid, in_flags[WIDTH]
//            outputs : stage_valid[DEPTH], stage_flags[DEPTH*WIDTH],
//                      out_valid, out_flags, pending, occupancy
// ----------------------------------------------------------------------------
module hazard_pipe_chain #(
   parameter int WIDTH = 1,
   parameter int DEPTH = 2
) (
   input  logic                clk,
   input  logic                rst_n,
   hazard_pipe_chain_if.slave  bus
);
   localparam int OCC_W = $clog2(DEPTH + 1);

   // An empty slot (a bubble) is valid=0 with flags=0. Every write below
   // keeps that pairing, so the flags of an invalid stage are always zero.
   logic [DEPTH-1:0]            valid_q, valid_d;
   logic [DEPTH-1:0][WIDTH-1:0] flags_q, flags_d;
   logic [WIDTH-1:0]            pend;
   logic [OCC_W-1:0]            occ;

   always_comb begin
      valid_d = valid_q;
      flags_d = flags_q;
      if (bus.stall) begin
         // While stalled, a flush still kills the entry it names. Every
         // other stage keeps its entry.
         for (int i = 0; i < DEPTH; i++) begin
            if (bus.flush[i]) begin
               valid_d[i] = 1'b0;
               flags_d[i] = '0;
            end
         end
      end else begin
         valid_d[0] = bus.in_valid;
         flags_d[0] = bus.in_valid ? bus.in_flags : '0;
         // A flushed stage still takes its upstream value. The flush only
         // stops the killed entry from moving on to the next stage.
         for (int i = 1; i < DEPTH; i++) begin
            if (bus.flush[i-1]) begin
               valid_d[i] = 1'b0;
               flags_d[i] = '0;
            end else begin
               valid_d[i] = valid_q[i-1];
               flags_d[i] = flags_q[i-1];
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= '0;
         flags_q <= '0;
      end else begin
         valid_q <= valid_d;
         flags_q <= flags_d;
      end
   end

   // The status outputs come straight from the stage registers, so they
   // describe the current cycle with no added latency.
   always_comb begin
      pend = '0;
      occ  = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (valid_q[i]) begin
            pend = pend | flags_q[i];
            occ  = occ + OCC_W'(1);
         end
      end
   end

   assign bus.stage_valid = valid_q;
   assign bus.stage_flags = flags_q;
   assign bus.out_valid   = valid_q[DEPTH-1];
   assign bus.out_flags   = flags_q[DEPTH-1];
   assign bus.pending     = pend;
   assign bus.occupancy   = occ;
endmodule

// File: tb/tb_hazard_pipe_chain.sv
// ----------------------------------------------------------------------------
// tb_hazard_pipe_chain
// Bench for hazard_pipe_chain. The main instance uses WIDTH=4, DEPTH=3 and
// a second instance uses DEPTH=1.
// ----------------------------------------------------------------------------
module tb_hazard_pipe_chain;
   localparam int W = 4;
   localparam int D = 3;

   // ---------------- clock / reset ----------------
   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   hazard_pipe_chain_if #(.WIDTH(W), .DEPTH(D)) bus ();
   hazard_pipe_chain_if #(.WIDTH(W), .DEPTH(1)) bus1 ();

   hazard_pipe_chain #(.WIDTH(W), .DEPTH(D)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   hazard_pipe_chain #(.WIDTH(W), .DEPTH(1)) dut1 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus1)
   );

   // ---------------- vector table ----------------
   typedef struct {
      logic        stall;
      logic [2:0]  flush;
      logic        in_valid;
      logic [3:0]  in_flags;
      logic [2:0]  e_valid;
      logic [11:0] e_flags;
      logic [3:0]  e_pend;
      logic [1:0]  e_occ;
   } vec_t;

   localparam int NV = 29;
   vec_t tbl [NV];

   function automatic vec_t mk(input logic s, input logic [2:0] f, input logic v,
                               input logic [3:0] fl, input logic [2:0] ev,
                               input logic [11:0] ef, input logic [3:0] ep,
                               input logic [1:0] eo);
      vec_t r;
      r.stall    = s;
      r.flush    = f;
      r.in_valid = v;
      r.in_flags = fl;
      r.e_valid  = ev;
      r.e_flags  = ef;
      r.e_pend   = ep;
      r.e_occ    = eo;
      return r;
   endfunction

   // ---------------- scoreboard ----------------
   logic [W:0] exp_q[$];
   logic [W:0] exp1_q[$];
   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic chk_all(input string tag, input logic [2:0] ev, input logic [11:0] ef,
                          input logic [3:0] ep, input logic [1:0] eo);
      logic [11:0] sf;
      sf = bus.stage_flags;
      chk({tag, " stage_valid"}, 32'(bus.stage_valid), 32'(ev));
      chk({tag, " stage_flags"}, 32'(sf), 32'(ef));
      chk({tag, " out_valid"},   32'(bus.out_valid), 32'(ev[2]));
      chk({tag, " out_flags"},   32'(bus.out_flags), 32'(ef[11:8]));
      chk({tag, " pending"},     32'(bus.pending), 32'(ep));
      chk({tag, " occupancy"},   32'(bus.occupancy), 32'(eo));
   endtask

   // ---------------- driver tasks ----------------
   task automatic drive(input logic s, input logic [2:0] f, input logic v, input logic [3:0] fl);
      bus.stall    = s;
      bus.flush    = f;
      bus.in_valid = v;
      bus.in_flags = fl;
   endtask

   task automatic drive1(input logic s, input logic f, input logic v, input logic [3:0] fl);
      bus1.stall    = s;
      bus1.flush    = f;
      bus1.in_valid = v;
      bus1.in_flags = fl;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // ---------------- test sequence ----------------
   initial begin
      logic [3:0]  p;
      logic [1:0]  o;
      logic        o1;
      logic [3:0]  p1;
      logic        s, v;
      logic [3:0]  f;

      tbl[0]  = mk(0, 3'b000, 1, 4'hA, 3'b001, 12'h00A, 4'hA, 2'd1);
      tbl[1]  = mk(0, 3'b000, 0, 4'h0, 3'b010, 12'h0A0, 4'hA, 2'd1);
      tbl[2]  = mk(0, 3'b000, 0, 4'h0, 3'b100, 12'hA00, 4'hA, 2'd1);
      tbl[3]  = mk(0, 3'b000, 0, 4'hF, 3'b000, 12'h000, 4'h0, 2'd0);
      tbl[4]  = mk(0, 3'b000, 1, 4'h1, 3'b001, 12'h001, 4'h1, 2'd1);
      tbl[5]  = mk(0, 3'b000, 1, 4'h2, 3'b011, 12'h012, 4'h3, 2'd2);
      tbl[6]  = mk(0, 3'b000, 1, 4'h3, 3'b111, 12'h123, 4'h3, 2'd3);
      tbl[7]  = mk(1, 3'b000, 1, 4'hF, 3'b111, 12'h123, 4'h3, 2'd3);
      tbl[8]  = mk(1, 3'b000, 1, 4'hF, 3'b111, 12'h123, 4'h3, 2'd3);
      tbl[9]  = mk(0, 3'b000, 0, 4'hF, 3'b110, 12'h230, 4'h3, 2'd2);
      tbl[10] = mk(0, 3'b000, 1, 4'h7, 3'b101, 12'h307, 4'h7, 2'd2);
      tbl[11] = mk(0, 3'b000, 1, 4'h6, 3'b011, 12'h076, 4'h7, 2'd2);
      tbl[12] = mk(0, 3'b000, 1, 4'h5, 3'b111, 12'h765, 4'h7, 2'd3);
      tbl[13] = mk(0, 3'b010, 1, 4'h9, 3'b011, 12'h059, 4'hD, 2'd2);
      tbl[14] = mk(0, 3'b000, 1, 4'h7, 3'b111, 12'h597, 4'hF, 2'd3);
      tbl[15] = mk(0, 3'b000, 1, 4'h6, 3'b111, 12'h976, 4'hF, 2'd3);
      tbl[16] = mk(0, 3'b000, 1, 4'h5, 3'b111, 12'h765, 4'h7, 2'd3);
      tbl[17] = mk(1, 3'b001, 1, 4'h9, 3'b110, 12'h760, 4'h7, 2'd2);
      tbl[18] = mk(0, 3'b100, 0, 4'h0, 3'b100, 12'h600, 4'h6, 2'd1);
      tbl[19] = mk(0, 3'b100, 1, 4'h2, 3'b001, 12'h002, 4'h2, 2'd1);
      tbl[20] = mk(0, 3'b000, 1, 4'h3, 3'b011, 12'h023, 4'h3, 2'd2);
      tbl[21] = mk(0, 3'b000, 1, 4'h4, 3'b111, 12'h234, 4'h7, 2'd3);
      tbl[22] = mk(1, 3'b100, 1, 4'h1, 3'b011, 12'h034, 4'h7, 2'd2);
      tbl[23] = mk(1, 3'b111, 1, 4'h1, 3'b000, 12'h000, 4'h0, 2'd0);
      tbl[24] = mk(0, 3'b000, 1, 4'h8, 3'b001, 12'h008, 4'h8, 2'd1);
      tbl[25] = mk(0, 3'b001, 1, 4'h4, 3'b001, 12'h004, 4'h4, 2'd1);
      tbl[26] = mk(0, 3'b000, 0, 4'h0, 3'b010, 12'h040, 4'h4, 2'd1);
      tbl[27] = mk(0, 3'b000, 0, 4'h0, 3'b100, 12'h400, 4'h4, 2'd1);
      tbl[28] = mk(0, 3'b000, 0, 4'h0, 3'b000, 12'h000, 4'h0, 2'd0);

      drive(0, 3'b000, 0, 4'h0);
      drive1(0, 1'b0, 0, 4'h0);

      // Reset is held across a clock edge, then released and left idle.
      #2;
      chk_all("reset", 3'b000, 12'h000, 4'h0, 2'd0);
      chk("reset d1 out_valid", 32'(bus1.out_valid), 32'd0);
      step();
      chk_all("reset_held", 3'b000, 12'h000, 4'h0, 2'd0);
      #2 rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk_all($sformatf("idle%0d", i), 3'b000, 12'h000, 4'h0, 2'd0);
      end

      // Apply the vector table.
      for (int i = 0; i < NV; i++) begin
         drive(tbl[i].stall, tbl[i].flush, tbl[i].in_valid, tbl[i].in_flags);
         step();
         chk_all($sformatf("vec%0d", i), tbl[i].e_valid, tbl[i].e_flags,
                 tbl[i].e_pend, tbl[i].e_occ);
      end

      // Pulse the asynchronous reset between edges while entries are in flight.
      drive(0, 3'b000, 1, 4'h7);
      step();
      drive(0, 3'b000, 1, 4'h8);
      step();
      chk("preload occupancy", 32'(bus.occupancy), 32'd2);
      #2 rst_n = 1'b0;
      #1;
      chk_all("async_rst", 3'b000, 12'h000, 4'h0, 2'd0);
      drive(0, 3'b000, 1, 4'hA);
      drive1(0, 1'b0, 1, 4'hA);
      #2 rst_n = 1'b1;
      step();
      chk("post_rst e1 out_valid", 32'(bus.out_valid), 32'd0);
      chk("post_rst e1 stage_valid", 32'(bus.stage_valid), 32'b001);
      chk("d1 e1 out_valid", 32'(bus1.out_valid), 32'd1);
      chk("d1 e1 out_flags", 32'(bus1.out_flags), 32'hA);
      drive(0, 3'b000, 0, 4'h0);
      drive1(0, 1'b0, 0, 4'h0);
      step();
      chk("post_rst e2 out_valid", 32'(bus.out_valid), 32'd0);
      chk("d1 e2 out_valid", 32'(bus1.out_valid), 32'd0);
      step();
      chk("post_rst e3 out_valid", 32'(bus.out_valid), 32'd1);
      chk("post_rst e3 out_flags", 32'(bus.out_flags), 32'hA);

      // DEPTH=1: a flush while stalled kills the single stage.
      drive1(0, 1'b0, 1, 4'h5);
      step();
      chk("d1 load out_flags", 32'(bus1.out_flags), 32'h5);
      chk("d1 load pending", 32'(bus1.pending), 32'h5);
      drive1(1, 1'b1, 1, 4'h6);
      step();
      chk("d1 flush out_valid", 32'(bus1.out_valid), 32'd0);
      chk("d1 flush out_flags", 32'(bus1.out_flags), 32'd0);
      chk("d1 flush occupancy", 32'(bus1.occupancy), 32'd0);
      drive1(0, 1'b0, 0, 4'h0);

      // Reset once more, then run random stall/entry traffic against the scoreboard.
      #2 rst_n = 1'b0;
      #2 rst_n = 1'b1;
      for (int i = 0; i < D; i++) exp_q.push_back('0);
      exp1_q.push_back('0);
      for (int n = 0; n < 300; n++) begin
         p = '0;
         o = '0;
         for (int k = 0; k < exp_q.size(); k++) begin
            if (exp_q[k][W]) begin
               p = p | exp_q[k][W-1:0];
               o = o + 2'd1;
            end
         end
         p1 = exp1_q[0][W] ? exp1_q[0][W-1:0] : 4'h0;
         o1 = exp1_q[0][W];
         chk("sb out", 32'({bus.out_valid, bus.out_flags}), 32'(exp_q[0]));
         chk("sb pending", 32'(bus.pending), 32'(p));
         chk("sb occupancy", 32'(bus.occupancy), 32'(o));
         chk("sb d1 out", 32'({bus1.out_valid, bus1.out_flags}), 32'(exp1_q[0]));
         chk("sb d1 pending", 32'(bus1.pending), 32'(p1));
         chk("sb d1 occupancy", 32'(bus1.occupancy), 32'(o1));
         s = ($urandom_range(0, 3) == 0);
         v = 1'($urandom_range(0, 1));
         f = 4'($urandom_range(0, 15));
         drive(s, 3'b000, v, f);
         drive1(s, 1'b0, v, f);
         if (!s) begin
            void'(exp_q.pop_front());
            exp_q.push_back(v ? {1'b1, f} : '0);
            void'(exp1_q.pop_front());
            exp1_q.push_back(v ? {1'b1, f} : '0);
         end
         step();
      end
      chk("sb final out", 32'({bus.out_valid, bus.out_flags}), 32'(exp_q[0]));
      chk("sb final d1 out", 32'({bus1.out_valid, bus1.out_flags}), 32'(exp1_q[0]));

      // ---------------- report ----------------
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
